// File: rtl/kronos_scoreboard.sv
// kronos_scoreboard: register scoreboard sitting between ID and EX.
// Tracks outstanding writes per architectural register (x1..x31), decides
// whether the decoded instruction may issue, selects forwarded operands and
// limits the number of issued-but-unretired instructions to two.
//
// Handshake: ID presents an instruction with dec_vld; the block raises ex_vld
// when it may issue and the instruction transfers to EX on ex_vld & ex_rdy.
// dec_rdy reports that ID's instruction left this cycle, either by issuing
// or by being discarded with flush. ex_vld never depends on ex_rdy.

module kronos_scoreboard (
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_vld,
   output logic        dec_rdy,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic        dec_op1_regrd,
   input  logic        dec_op2_regrd,
   input  logic [4:0]  dec_rd,
   input  logic        dec_rd_write,
   output logic        ex_vld,
   input  logic        ex_rdy,
   input  logic        fwd_vld,
   input  logic [4:0]  fwd_rd,
   input  logic        wb_vld,
   input  logic [4:0]  wb_rd,
   input  logic        flush,
   output logic        op1_fwd,
   output logic        op2_fwd,
   output logic [1:0]  inflight,
   output logic [15:0] stall_cnt
);

   // Outstanding-write count per register; entry 0 is held at zero.
   logic [1:0] pend [32];

   logic [1:0] pend_rs1;
   logic [1:0] pend_rs2;
   logic       haz1;
   logic       haz2;
   logic       fwd_clr1;
   logic       fwd_clr2;
   logic       wb_clr1;
   logic       wb_clr2;
   logic       blk1;
   logic       blk2;
   logic       limit;
   logic       stall;
   logic       issue;

   // Next value of one pending counter. A same-cycle increment and decrement
   // cancel; otherwise the count saturates at 3 and never wraps below 0.
   function automatic logic [1:0] pend_next(input logic [1:0] cur,
                                            input logic       inc,
                                            input logic       dec);
      logic [1:0] nxt;
      nxt = cur;
      if (inc && !dec && cur != 2'd3)
         nxt = cur + 2'd1;
      else if (dec && !inc && cur != 2'd0)
         nxt = cur - 2'd1;
      return nxt;
   endfunction

   assign pend_rs1 = pend[dec_rs1];
   assign pend_rs2 = pend[dec_rs2];

   // A source is hazarded while any write to it is outstanding. With exactly
   // one write outstanding, it can be taken from EX (forward) or from the
   // retiring write-back this cycle. Two outstanding writes always stall,
   // since the forwarded value might belong to the older of the two.
   assign haz1     = dec_op1_regrd & (dec_rs1 != 5'd0) & (pend_rs1 != 2'd0);
   assign haz2     = dec_op2_regrd & (dec_rs2 != 5'd0) & (pend_rs2 != 2'd0);
   assign fwd_clr1 = fwd_vld & (fwd_rd == dec_rs1) & (pend_rs1 == 2'd1);
   assign fwd_clr2 = fwd_vld & (fwd_rd == dec_rs2) & (pend_rs2 == 2'd1);
   assign wb_clr1  = wb_vld & (wb_rd == dec_rs1) & (pend_rs1 == 2'd1);
   assign wb_clr2  = wb_vld & (wb_rd == dec_rs2) & (pend_rs2 == 2'd1);
   assign blk1     = haz1 & ~fwd_clr1 & ~wb_clr1;
   assign blk2     = haz2 & ~fwd_clr2 & ~wb_clr2;

   // At two in flight, a retirement in the same cycle frees a slot.
   assign limit = (inflight >= 2'd2) & ~wb_vld;
   assign stall = dec_vld & (blk1 | blk2 | limit);

   assign ex_vld  = ~rst & dec_vld & ~stall & ~flush;
   assign dec_rdy = ~rst & ((ex_vld & ex_rdy) | (dec_vld & flush));
   assign op1_fwd = ~rst & haz1 & fwd_clr1;
   assign op2_fwd = ~rst & haz2 & fwd_clr2;
   assign issue   = ex_vld & ex_rdy;

   // Pending counters: issue of a writer increments, write-back decrements.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 32; i++) begin
         if (rst || i == 0)
            pend[i] <= 2'd0;
         else
            pend[i] <= pend_next(pend[i],
                                 issue & dec_rd_write & (dec_rd == 5'(i)),
                                 wb_vld & (wb_rd == 5'(i)));
      end
   end

   // In-flight count: issues minus retirements, never wrapping.
   always_ff @(posedge clk) begin
      if (rst)
         inflight <= 2'd0;
      else begin
         case ({issue, wb_vld})
            2'b10:   if (inflight != 2'd3) inflight <= inflight + 2'd1;
            2'b01:   if (inflight != 2'd0) inflight <= inflight - 2'd1;
            default: inflight <= inflight;
         endcase
      end
   end

   // Stall counter: counts cycles where a live instruction is held back.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= 16'd0;
      else if (dec_vld && stall && !flush && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end

endmodule
